mac_array_ctrl: RTL and testbench
=================================

// Module: mac_array_ctrl
// PURPOSE
//  Sequencer for the row x col MAC array: runs one kernel-load + execute job per start pulse.
//  Drives the 2-bit array instruction (inst_w: bit0 kernel load, bit1 execute), data_mode and mode.
//  Also drives the L0 (west-feed) read enable and the OFIFO write strobes, and counts returned results.
//  Sits between the core top-level FSM and mac_array / L0 / OFIFO.
// PARAMETERS
//  row    8   array rows = kernel-load cycles per job
//  col    8   array columns = width of valid / ofifo_wr
//  CNT_W  8   width of execute-vector count (max 2^CNT_W-1 vectors per job)
//  TMO    64  drain watchdog limit in cycles (used only with MAC_CTRL_TIMEOUT_EN)
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-low reset
//  start          in   1      job request; accepted only in IDLE
//  cfg_data_mode  in   1      1=broadcast inst to all rows, 0=row-skewed; sampled on accepted start
//  cfg_mode       in   1      array mode bit; sampled on accepted start
//  cfg_nexec      in   CNT_W  number of execute vectors; sampled on accepted start
//  l0_empty       in   1      L0 has no vector available
//  ofifo_full     in   1      OFIFO cannot accept a result row
//  valid          in   col    per-column result valid from array
//  inst_w         out  2      instruction to array (00 idle, 01 load, 10 exec)
//  data_mode      out  1      latched cfg_data_mode
//  mode           out  1      latched cfg_mode
//  l0_rd          out  1      L0 read enable
//  ofifo_wr       out  col    OFIFO column write strobes
//  busy           out  1      high from the cycle after accept until done
//  done           out  1      one-cycle completion pulse
//  err            out  1      watchdog fired (0 without MAC_CTRL_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; all counters 0; every output 0 immediately; mid-job reset aborts the job, no done.
//  - States: IDLE -> LOAD -> FLUSH -> EXEC -> DRAIN -> DONE -> IDLE.
//  - IDLE: start=1 at edge latches cfg_*; next cycle LOAD, busy=1. start outside IDLE is ignored.
//  - LOAD: issue row read slots. Slot fires when l0_empty=0: l0_rd=1, load counter +1.
//    l0_empty=1: l0_rd=0, counter holds. After the row-th slot -> FLUSH.
//  - inst_w is registered; it carries the op of l0_rd from the previous cycle so it aligns with L0 data (1-cycle read latency).
//    Cycles with no slot give inst_w=00.
//  - FLUSH: inst_w=00 for row cycles if data_mode=0, else 1 cycle, so skewed loads finish. Then EXEC, or DONE if nexec=0.
//  - EXEC: like LOAD with op=10 and nexec slots. A slot fires only when l0_empty=0 and ofifo_full=0. After the last slot -> DRAIN.
//  - ofifo_wr = valid & {col{cap}}, combinational, zero latency; cap=1 in EXEC/DRAIN, else 0.
//    valid arriving outside EXEC/DRAIN is dropped.
//  - rcv counter +1 on each valid[col-1]=1 in EXEC/DRAIN. DRAIN -> DONE when rcv==nexec.
//    This includes the same cycle the last slot is issued, if already satisfied.
//  - DONE: done=1, busy=0 for one cycle, then IDLE. start in the DONE cycle is ignored.
//  - data_mode/mode hold the latched values from accept until the next accept; 0 after reset.
//  - Counters are CNT_W-bit and never wrap: slot and rcv counts saturate at nexec.
// CONFIGURATION
//  MAC_CTRL_TIMEOUT_EN defined: DRAIN watchdog counts cycles since the last valid[col-1].
//    On reaching TMO: err=1 (sticky until next accept or reset), then DONE with a normal done pulse.
//  Undefined: no watchdog; DRAIN waits indefinitely; err tied 0.
// TESTING (row=8,col=8)
//  1. reset=0 mid-EXEC -> same cycle inst_w=00, l0_rd=0, busy=0, ofifo_wr=0; no done after release.
//  2. start, data_mode=0, nexec=4, l0_empty=0, array returns valid 8 cyc after each exec
//     -> 8 cyc inst_w=01, 8 cyc 00, 4 cyc 10; 4 ofifo_wr=8'hFF pulses; done once.
//  3. Same job with data_mode=1 -> FLUSH 1 cycle; done 7 cycles earlier than scenario 2.
//  4. l0_empty=1 for 3 cycles during LOAD -> l0_rd gaps of 3, inst_w 00 gaps; still exactly 8 load ops.
//  5. nexec=0 -> LOAD, FLUSH, DONE; inst_w never 10; ofifo_wr stays 0.
//  6. MAC_CTRL_TIMEOUT_EN, TMO=64, nexec=3, only 2 valids returned -> err=1 and done 64 cycles after the 2nd valid.

Source files
------------

// File: rtl/mac_array_ctrl_if.sv
// mac_array_ctrl_if
//   Bundles the handshake and data-path control signals between the core FSM,
//   the MAC array sequencer and the L0 / OFIFO / array side.
//   master : core / array environment (drives requests, FIFO status, valid)
//   slave  : mac_array_ctrl (drives instruction, modes, strobes, status)
//   Signals:
//     start, cfg_data_mode, cfg_mode, cfg_nexec[CNT_W]  job request + config
//     l0_empty, ofifo_full, valid[col]                  FIFO status, array results
//     inst_w[2], data_mode, mode                        array control
//     l0_rd, ofifo_wr[col]                              FIFO strobes
//     busy, done, err                                   job status
interface mac_array_ctrl_if #(
  parameter int col   = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             cfg_data_mode;
  logic             cfg_mode;
  logic [CNT_W-1:0] cfg_nexec;
  logic             l0_empty;
  logic             ofifo_full;
  logic [col-1:0]   valid;
  logic [1:0]       inst_w;
  logic             data_mode;
  logic             mode;
  logic             l0_rd;
  logic [col-1:0]   ofifo_wr;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, cfg_data_mode, cfg_mode, cfg_nexec, l0_empty, ofifo_full, valid,
    input  inst_w, data_mode, mode, l0_rd, ofifo_wr, busy, done, err
  );

  modport slave (
    input  start, cfg_data_mode, cfg_mode, cfg_nexec, l0_empty, ofifo_full, valid,
    output inst_w, data_mode, mode, l0_rd, ofifo_wr, busy, done, err
  );
endinterface

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl
//   Sequencer for the row x col MAC array. Each accepted start runs one job:
//   row kernel-load slots, a flush gap, cfg_nexec execute slots, then a drain
//   phase that waits for every result row before pulsing done.
//   Ports:
//     clk      rising-edge clock
//     reset    asynchronous, active-low reset
//     ctrl_if  mac_array_ctrl_if.slave (config, FIFO status, array control)
//   Optional feature macro: MAC_CTRL_TIMEOUT_EN enables the drain watchdog that
//   raises err and finishes the job after TMO cycles without a result.
module mac_array_ctrl #(
  parameter int row   = 8,
  parameter int col   = 8,
  parameter int CNT_W = 8,
  parameter int TMO   = 64
) (
  input  logic             clk,
  input  logic             reset,
  mac_array_ctrl_if.slave  ctrl_if
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, EXEC, DRAIN, DONE} state_e;

  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(row - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0] rcv_q, rcv_d;
  logic [CNT_W-1:0] nexec_q;
  logic             dm_q, mode_q;
  logic [1:0]       inst_q, inst_d;
  logic             accept, load_fire, exec_fire, cap, wdog_fire;
  logic [CNT_W-1:0] flush_last;

  assign accept     = (state_q == IDLE) && ctrl_if.start;
  assign cap        = (state_q == EXEC) || (state_q == DRAIN);
  // Row-skewed loads need row idle cycles to ripple down; broadcast needs one.
  assign flush_last = dm_q ? '0 : ROW_LAST;

  // Next-state logic: slot_q is reused as the load, flush and exec counter
  // and is cleared on every phase change.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    rcv_d     = rcv_q;
    load_fire = 1'b0;
    exec_fire = 1'b0;
    if (cap && ctrl_if.valid[col-1] && (rcv_q < nexec_q)) begin
      rcv_d = rcv_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          slot_d  = '0;
          rcv_d   = '0;
        end
      end
      LOAD: begin
        if (!ctrl_if.l0_empty) begin
          load_fire = 1'b1;
          slot_d    = slot_q + 1'b1;
          if (slot_q == ROW_LAST) begin
            state_d = FLUSH;
            slot_d  = '0;
          end
        end
      end
      FLUSH: begin
        if (slot_q == flush_last) begin
          slot_d  = '0;
          state_d = (nexec_q == '0) ? DONE : EXEC;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      EXEC: begin
        if (!ctrl_if.l0_empty && !ctrl_if.ofifo_full && (slot_q < nexec_q)) begin
          exec_fire = 1'b1;
          slot_d    = slot_q + 1'b1;
          if (slot_q == nexec_q - 1'b1) begin
            state_d = (rcv_q == nexec_q) ? DONE : DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((rcv_q == nexec_q) || wdog_fire) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // L0 data arrives one cycle after l0_rd, so the op is delayed to match.
    inst_d = {exec_fire, load_fire};
  end

  // State, counters, latched configuration and the registered instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      rcv_q   <= '0;
      nexec_q <= '0;
      dm_q    <= 1'b0;
      mode_q  <= 1'b0;
      inst_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      rcv_q   <= rcv_d;
      inst_q  <= inst_d;
      if (accept) begin
        nexec_q <= ctrl_if.cfg_nexec;
        dm_q    <= ctrl_if.cfg_data_mode;
        mode_q  <= ctrl_if.cfg_mode;
      end
    end
  end

`ifdef MAC_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_N = CNT_W'(TMO);

  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             err_q;

  // Watchdog holds the number of cycles since the last result row; the
  // valid cycle itself loads 1 so the value reaching TMO means TMO cycles
  // have passed. It saturates rather than wrapping.
  always_comb begin
    wdog_d = wdog_q;
    if (!cap) begin
      wdog_d = '0;
    end else if (ctrl_if.valid[col-1]) begin
      wdog_d = CNT_W'(1);
    end else if (wdog_q != TMO_N) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  assign wdog_fire = (state_q == DRAIN) && (wdog_d == TMO_N) && (rcv_q != nexec_q);

  // Watchdog counter and the sticky error flag, cleared by the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (accept) begin
        err_q <= 1'b0;
      end else if (wdog_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ctrl_if.err = err_q;
`else
  assign wdog_fire   = 1'b0;
  assign ctrl_if.err = 1'b0;
`endif

  assign ctrl_if.inst_w    = inst_q;
  assign ctrl_if.data_mode = dm_q;
  assign ctrl_if.mode      = mode_q;
  assign ctrl_if.l0_rd     = load_fire | exec_fire;
  // Results are only forwarded while a job is executing or draining.
  assign ctrl_if.ofifo_wr  = ctrl_if.valid & {col{cap}};
  assign ctrl_if.busy      = (state_q == LOAD) || (state_q == FLUSH) || cap;
  assign ctrl_if.done      = (state_q == DONE);

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl
//   Directed bench for mac_array_ctrl with row=8, col=8, CNT_W=8, TMO=64.
//   A small array model returns an all-ones valid row 8 cycles after each
//   execute instruction. Cycle 1 is the first cycle after the accept edge.
module tb_mac_array_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mac_array_ctrl_if #(.col(8), .CNT_W(8)) bus ();

  mac_array_ctrl #(.row(8), .col(8), .CNT_W(8), .TMO(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (bus)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  logic [8:0] pipe;
  int         valSeen;
  int         valLimit;
  bit         valAll;

  int         n01, n10, first01, first10, nRd, nWrFF, nWrBad;
  int         nDone, doneCyc, nBusy, nErr;
  logic       postBusy, postDone, modeOut, dmOut, errAtDone;
  logic [1:0] instLog [0:255];
  logic       rdLog   [0:255];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and update the array model's returned valid row.
  task automatic tick();
    @(posedge clk);
    #1;
    pipe = {pipe[7:0], bus.inst_w == 2'b10};
    if (pipe[8] && valSeen < valLimit) begin
      valSeen++;
      bus.valid = 8'hFF;
    end else begin
      bus.valid = valAll ? 8'hFF : 8'h00;
    end
  endtask

  // Run one job from IDLE and record per-cycle observations until one
  // cycle after done (or a 200-cycle bound).
  task automatic applyStimulus(input bit dm, input bit md, input logic [7:0] nx,
                               input int emptyFrom, input int emptyLen, input bit holdStart);
    n01 = 0; n10 = 0; first01 = 0; first10 = 0; nRd = 0; nWrFF = 0; nWrBad = 0;
    nDone = 0; doneCyc = 0; nBusy = 0; nErr = 0;
    postBusy = 1'bx; postDone = 1'bx; modeOut = 1'bx; dmOut = 1'bx; errAtDone = 1'bx;
    for (int i = 0; i < 256; i++) begin
      instLog[i] = 2'bxx;
      rdLog[i]   = 1'bx;
    end
    pipe = '0;
    valSeen = 0;
    bus.cfg_data_mode = dm;
    bus.cfg_mode      = md;
    bus.cfg_nexec     = nx;
    bus.l0_empty      = 1'b0;
    bus.start         = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      bus.start         = holdStart;
      bus.cfg_data_mode = ~dm;
      bus.cfg_mode      = ~md;
      bus.cfg_nexec     = ~nx;
      bus.l0_empty      = (c >= emptyFrom) && (c < emptyFrom + emptyLen);
      #1;
      if (nDone > 0 && c == doneCyc + 1) begin
        postBusy = bus.busy;
        postDone = bus.done;
        break;
      end
      instLog[c] = bus.inst_w;
      rdLog[c]   = bus.l0_rd;
      if (bus.inst_w == 2'b01) begin
        n01++;
        if (first01 == 0) first01 = c;
      end
      if (bus.inst_w == 2'b10) begin
        n10++;
        if (first10 == 0) first10 = c;
      end
      if (bus.l0_rd) nRd++;
      if (bus.ofifo_wr == 8'hFF) nWrFF++;
      else if (bus.ofifo_wr != 8'h00) nWrBad++;
      if (bus.busy) nBusy++;
      if (bus.err) nErr++;
      if (bus.done) begin
        nDone++;
        doneCyc   = c;
        modeOut   = bus.mode;
        dmOut     = bus.data_mode;
        errAtDone = bus.err;
      end
    end
    bus.start    = 1'b0;
    bus.l0_empty = 1'b0;
    bus.valid    = 8'h00;
  endtask

  int doneAfterReset;
  int busyAfterReset;

  initial begin
    reset             = 1'b0;
    bus.start         = 1'b0;
    bus.cfg_data_mode = 1'b0;
    bus.cfg_mode      = 1'b0;
    bus.cfg_nexec     = '0;
    bus.l0_empty      = 1'b0;
    bus.ofifo_full    = 1'b0;
    bus.valid         = 8'hFF;
    valAll            = 1'b0;
    valLimit          = 1000;
    pipe              = '0;
    valSeen           = 0;
    #12;
    $display("[TB] reset state");
    checkOutput("rst_inst_w", bus.inst_w, 2'b00);
    checkOutput("rst_l0_rd", bus.l0_rd, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_ofifo_wr", bus.ofifo_wr, 8'h00);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_mode", {bus.data_mode, bus.mode}, 2'b00);
    bus.valid = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] skewed job, nexec=4, start held high");
    applyStimulus(1'b0, 1'b1, 8'd4, 0, 0, 1'b1);
    checkOutput("s2_first01", first01, 2);
    checkOutput("s2_n01", n01, 8);
    checkOutput("s2_inst9", instLog[9], 2'b01);
    checkOutput("s2_inst10", instLog[10], 2'b00);
    checkOutput("s2_inst17", instLog[17], 2'b00);
    checkOutput("s2_first10", first10, 18);
    checkOutput("s2_inst21", instLog[21], 2'b10);
    checkOutput("s2_inst22", instLog[22], 2'b00);
    checkOutput("s2_n10", n10, 4);
    checkOutput("s2_nRd", nRd, 12);
    checkOutput("s2_nWrFF", nWrFF, 4);
    checkOutput("s2_nWrBad", nWrBad, 0);
    checkOutput("s2_nDone", nDone, 1);
    checkOutput("s2_doneCyc", doneCyc, 31);
    checkOutput("s2_nBusy", nBusy, 30);
    checkOutput("s2_postBusy", postBusy, 0);
    checkOutput("s2_postDone", postDone, 0);
    checkOutput("s2_mode", modeOut, 1);
    checkOutput("s2_data_mode", dmOut, 0);
    checkOutput("s2_nErr", nErr, 0);

    $display("[TB] broadcast job, nexec=4");
    applyStimulus(1'b1, 1'b0, 8'd4, 0, 0, 1'b0);
    checkOutput("s3_inst9", instLog[9], 2'b01);
    checkOutput("s3_inst10", instLog[10], 2'b00);
    checkOutput("s3_first10", first10, 11);
    checkOutput("s3_n10", n10, 4);
    checkOutput("s3_nWrFF", nWrFF, 4);
    checkOutput("s3_nDone", nDone, 1);
    checkOutput("s3_doneCyc", doneCyc, 24);
    checkOutput("s3_data_mode", dmOut, 1);
    checkOutput("s3_mode", modeOut, 0);

    $display("[TB] reset during execute");
    pipe = '0;
    valSeen = 0;
    bus.cfg_data_mode = 1'b1;
    bus.cfg_mode      = 1'b1;
    bus.cfg_nexec     = 8'd4;
    bus.l0_empty      = 1'b0;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    bus.valid = 8'hFF;
    #1;
    checkOutput("s1_pre_inst_w", bus.inst_w, 2'b10);
    checkOutput("s1_pre_ofifo_wr", bus.ofifo_wr, 8'hFF);
    checkOutput("s1_pre_mode", bus.mode, 1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("s1_inst_w", bus.inst_w, 2'b00);
    checkOutput("s1_l0_rd", bus.l0_rd, 0);
    checkOutput("s1_busy", bus.busy, 0);
    checkOutput("s1_ofifo_wr", bus.ofifo_wr, 8'h00);
    checkOutput("s1_mode", {bus.data_mode, bus.mode}, 2'b00);
    bus.valid = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    doneAfterReset = 0;
    busyAfterReset = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      #1;
      if (bus.done) doneAfterReset++;
      if (bus.busy) busyAfterReset++;
    end
    checkOutput("s1_no_done", doneAfterReset, 0);
    checkOutput("s1_no_busy", busyAfterReset, 0);
    bus.valid = 8'h00;

    $display("[TB] L0 empty for 3 cycles during load");
    applyStimulus(1'b1, 1'b0, 8'd2, 3, 3, 1'b0);
    checkOutput("s4_n01", n01, 8);
    checkOutput("s4_nRd", nRd, 10);
    checkOutput("s4_rd3", rdLog[3], 0);
    checkOutput("s4_rd5", rdLog[5], 0);
    checkOutput("s4_rd6", rdLog[6], 1);
    checkOutput("s4_inst3", instLog[3], 2'b01);
    checkOutput("s4_inst4", instLog[4], 2'b00);
    checkOutput("s4_inst6", instLog[6], 2'b00);
    checkOutput("s4_inst7", instLog[7], 2'b01);
    checkOutput("s4_inst12", instLog[12], 2'b01);
    checkOutput("s4_doneCyc", doneCyc, 25);

    $display("[TB] zero execute vectors, valid forced high");
    valAll = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 0, 0, 1'b0);
    valAll = 1'b0;
    bus.valid = 8'h00;
    checkOutput("s5_n01", n01, 8);
    checkOutput("s5_n10", n10, 0);
    checkOutput("s5_nWrFF", nWrFF, 0);
    checkOutput("s5_nWrBad", nWrBad, 0);
    checkOutput("s5_nDone", nDone, 1);
    checkOutput("s5_doneCyc", doneCyc, 17);

`ifdef MAC_CTRL_TIMEOUT_EN
    $display("[TB] drain watchdog, 2 of 3 results");
    valLimit = 2;
    applyStimulus(1'b1, 1'b0, 8'd3, 0, 0, 1'b0);
    valLimit = 1000;
    checkOutput("s6_nWrFF", nWrFF, 2);
    checkOutput("s6_nDone", nDone, 1);
    checkOutput("s6_doneCyc", doneCyc, 84);
    checkOutput("s6_errAtDone", errAtDone, 1);
    checkOutput("s6_err_sticky", bus.err, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
